// File: rtl/hps_uio_cmd.sv
// Framed command parser for the HPS user-I/O word stream: config write,
// video-timing table write and status read-back, all on clk_sys.
module hps_uio_cmd #(
  parameter logic [15:0] CFG_INIT    = 16'h0000,
  parameter int          VMODE_WORDS = 8,
  parameter logic [15:0] STATUS_VER  = 16'h0001
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      io_uio,
  input  logic                      io_strobe,
  input  logic [15:0]               io_din,
  output logic [15:0]               io_dout,
  output logic                      io_wait,
  input  logic [15:0]               status_in,
  output logic [15:0]               cfg,
  output logic                      cfg_stb,
  output logic                      cfg_ready,
  output logic [12*VMODE_WORDS-1:0] vmode_data,
  output logic                      vmode_stb,
  output logic [1:0]                o_dbg_state
);

  // Handshake: a rising edge of io_strobe while io_uio is high presents one
  // io_din word; io_wait high means io_dout is not yet valid, so the HPS
  // samples io_dout only once io_wait has dropped.

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_PAYLOAD, S_SKIP} state_t;

  localparam logic [3:0] LAST_IDX = 4'(VMODE_WORDS - 1);

  state_t      r_state, w_next;
  logic        r_old_strobe;
  logic        w_wev, w_take_cmd, w_take_pay, w_cmd_known;
  logic        w_set_cfg, w_vm_stage, w_vm_done, w_status_wev;
  logic [7:0]  r_cmd;
  logic [3:0]  r_widx;
  logic [1:0]  r_wait_cnt;
  logic [15:0] r_status, r_dout, r_cfg;
  logic        r_cfg_stb, r_cfg_ready, r_vmode_stb;
  logic [11:0] r_shadow [VMODE_WORDS];
  logic [12*VMODE_WORDS-1:0] r_vmode;

  assign w_wev       = io_strobe & ~r_old_strobe;
  assign w_cmd_known = (io_din[7:0] == 8'h01) || (io_din[7:0] == 8'h02) ||
                       (io_din[7:0] == 8'h20);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Dropping io_uio always wins, including over a word arriving that cycle.
  always_comb begin
    w_next     = r_state;
    w_take_cmd = 1'b0;
    w_take_pay = 1'b0;
    if (!io_uio) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_CMD;
        S_CMD: begin
          if (w_wev) begin
            w_take_cmd = 1'b1;
            w_next     = w_cmd_known ? S_PAYLOAD : S_SKIP;
          end
        end
        S_PAYLOAD, S_SKIP: w_take_pay = w_wev;
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign w_set_cfg    = w_take_pay && (r_state == S_PAYLOAD) && (r_cmd == 8'h01) && (r_widx == 4'd0);
  assign w_vm_stage   = w_take_pay && (r_state == S_PAYLOAD) && (r_cmd == 8'h20) && (r_widx <= LAST_IDX);
  assign w_vm_done    = w_vm_stage && (r_widx == LAST_IDX);
  assign w_status_wev = w_take_pay && (r_state == S_PAYLOAD) && (r_cmd == 8'h02);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_old_strobe <= 1'b0;
      r_cmd        <= 8'h00;
      r_widx       <= 4'd0;
    end else begin
      r_old_strobe <= io_strobe;
      if (!io_uio) begin
        r_cmd  <= 8'h00;
        r_widx <= 4'd0;
      end else if (w_take_cmd) begin
        r_cmd  <= io_din[7:0];
        r_widx <= 4'd0;
      end else if (w_take_pay && (r_widx != 4'd15)) begin
        r_widx <= r_widx + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cfg       <= CFG_INIT;
      r_cfg_stb   <= 1'b0;
      r_cfg_ready <= 1'b0;
      r_vmode     <= '0;
      r_vmode_stb <= 1'b0;
      for (int k = 0; k < VMODE_WORDS; k++) r_shadow[k] <= 12'h000;
    end else begin
      r_cfg_stb   <= 1'b0;
      r_vmode_stb <= 1'b0;
      if (w_set_cfg) begin
        r_cfg       <= io_din;
        r_cfg_stb   <= 1'b1;
        r_cfg_ready <= 1'b1;
      end
      for (int k = 0; k < VMODE_WORDS; k++) begin
        if (w_vm_stage && (r_widx == 4'(k))) r_shadow[k] <= io_din[11:0];
      end
      // The final word bypasses its shadow slot so the table lands in one cycle.
      if (w_vm_done) begin
        for (int k = 0; k < VMODE_WORDS - 1; k++) r_vmode[12*k +: 12] <= r_shadow[k];
        r_vmode[12*(VMODE_WORDS-1) +: 12] <= io_din[11:0];
        r_vmode_stb <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dout     <= 16'h0000;
      r_status   <= 16'h0000;
      r_wait_cnt <= 2'd0;
    end else if ((w_next == S_IDLE) && (r_state != S_IDLE)) begin
      r_dout     <= 16'h0000;
      r_wait_cnt <= 2'd0;
    end else if (w_take_cmd) begin
      r_dout     <= (io_din[7:0] == 8'h02) ? STATUS_VER : 16'h0000;
      r_wait_cnt <= (io_din[7:0] == 8'h02) ? 2'd2 : 2'd0;
    end else begin
      if (r_wait_cnt != 2'd0) begin
        r_status   <= status_in;
        r_dout     <= STATUS_VER;
        r_wait_cnt <= r_wait_cnt - 2'd1;
      end
      if (w_status_wev) r_dout <= (r_widx == 4'd0) ? r_status : 16'h0000;
    end
  end

  assign io_dout     = r_dout;
  assign io_wait     = (r_wait_cnt != 2'd0);
  assign cfg         = r_cfg;
  assign cfg_stb     = r_cfg_stb;
  assign cfg_ready   = r_cfg_ready;
  assign vmode_data  = r_vmode;
  assign vmode_stb   = r_vmode_stb;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hps_uio_cmd.sv
// Bench for hps_uio_cmd: directed frames from the test plan followed by
// random frames, all checked against a frame-level reference model.
module tb_hps_uio_cmd;

  localparam logic [15:0] CFG_INIT = 16'h0000;
  localparam logic [15:0] VER      = 16'h0001;
  localparam int          VW       = 8;

  logic              clk_sys = 1'b0;
  logic              reset_n, io_uio, io_strobe;
  logic [15:0]       io_din, io_dout, status_in, cfg;
  logic              io_wait, cfg_stb, cfg_ready, vmode_stb;
  logic [12*VW-1:0]  vmode_data;
  logic [1:0]        dbg_state;

  hps_uio_cmd #(.CFG_INIT(CFG_INIT), .VMODE_WORDS(VW), .STATUS_VER(VER)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .io_uio(io_uio), .io_strobe(io_strobe),
    .io_din(io_din), .io_dout(io_dout), .io_wait(io_wait), .status_in(status_in),
    .cfg(cfg), .cfg_stb(cfg_stb), .cfg_ready(cfg_ready), .vmode_data(vmode_data),
    .vmode_stb(vmode_stb), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] pw_q[$];
  logic [15:0] m_cfg;
  logic        m_ready;
  logic [11:0] m_vm [VW];
  int          m_nvm = 0;
  int          n_vm_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every cfg_stb must match the next predicted cfg write
  always @(negedge clk_sys) begin
    if (cfg_stb === 1'b1) begin
      if (exp_q.size() == 0) chk("cfg_stb_unexpected", 32'd1, 32'd0);
      else                   chk("cfg_stb_value", 32'(cfg), 32'(exp_q.pop_front()));
    end
    if (vmode_stb === 1'b1) n_vm_seen++;
    if ((cfg_stb === 1'b1) && (vmode_stb === 1'b1)) chk("dual_stb", 32'd1, 32'd0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: one word, strobe held for 'hold' edges then low for two
  task automatic send_word(input logic [15:0] w, input int hold, output logic [2:0] wv,
                           output logic cs, output logic vs,
                           output logic [15:0] d0, output logic [15:0] de);
    io_din = w; io_strobe = 1'b1;
    wv = 3'b000; cs = 1'b0; vs = 1'b0; d0 = 16'h0; de = 16'h0;
    for (int c = 0; c < hold + 2; c++) begin
      @(posedge clk_sys); #1;
      if (c < 3) wv[c] = io_wait;
      if (c == 0) begin cs = cfg_stb; vs = vmode_stb; d0 = io_dout; end
      if (c == hold - 1) io_strobe = 1'b0;
    end
    de = io_dout;
    io_din = 16'($urandom);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_cfg"}, 32'(cfg), 32'(m_cfg));
    chk({tag, "_ready"}, 32'(cfg_ready), 32'(m_ready));
    for (int k = 0; k < VW; k++) chk({tag, "_vmode"}, 32'(vmode_data[12*k +: 12]), 32'(m_vm[k]));
    chk({tag, "_vm_pulses"}, 32'(n_vm_seen), 32'(m_nvm));
    chk({tag, "_cfg_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // one whole frame: command word, payload from pw_q, then io_uio drop
  task automatic run_frame(input logic [15:0] cmd_w, input int hold, input logic [15:0] stat);
    logic [2:0]  wv;
    logic        cs, vs, ecs, evs, known;
    logic [15:0] d0, de, edout;
    logic [7:0]  cmd;
    cmd   = cmd_w[7:0];
    known = (cmd == 8'h01) || (cmd == 8'h02) || (cmd == 8'h20);
    status_in = stat;
    io_uio = 1'b1;
    @(posedge clk_sys); #1;
    send_word(cmd_w, hold, wv, cs, vs, d0, de);
    chk("cmd_wait", 32'(wv), (cmd == 8'h02) ? 32'd3 : 32'd0);
    chk("cmd_stb", 32'({cs, vs}), 32'd0);
    if (cmd == 8'h02) begin
      chk("dout_ver", 32'(d0), 32'(VER));
      chk("dout_ver_hold", 32'(de), 32'(VER));
    end else if (!known) begin
      chk("dout_skip_cmd", 32'(d0), 32'd0);
    end
    status_in = ~stat;
    for (int i = 0; i < pw_q.size(); i++) begin
      ecs = (cmd == 8'h01) && (i == 0);
      evs = (cmd == 8'h20) && (i == VW - 1);
      if (ecs) begin m_cfg = pw_q[i]; m_ready = 1'b1; exp_q.push_back(pw_q[i]); end
      if (evs) begin
        for (int k = 0; k < VW; k++) m_vm[k] = pw_q[k][11:0];
        m_nvm++;
      end
      send_word(pw_q[i], hold, wv, cs, vs, d0, de);
      chk("pay_cfg_stb", 32'(cs), 32'(ecs));
      chk("pay_vm_stb", 32'(vs), 32'(evs));
      chk("pay_wait", 32'(wv), 32'd0);
      if (cmd == 8'h02) begin
        edout = (i == 0) ? stat : 16'h0000;
        chk("status_dout", 32'(d0), 32'(edout));
        chk("status_dout_end", 32'(de), 32'(edout));
      end else if (!known) begin
        chk("dout_skip", 32'(de), 32'd0);
      end
    end
    io_uio = 1'b0;
    @(posedge clk_sys); #1;
    chk("idle_dout", 32'(io_dout), 32'd0);
    chk("idle_wait", 32'(io_wait), 32'd0);
    check_state("frame");
  endtask

  initial begin
    logic [2:0]  wv;
    logic        cs, vs;
    logic [15:0] d0, de;
    logic [7:0]  cmd;
    int          nw;

    reset_n = 1'b0; io_uio = 1'b0; io_strobe = 1'b0; io_din = 16'h0; status_in = 16'h0;
    m_cfg = CFG_INIT; m_ready = 1'b0;
    for (int k = 0; k < VW; k++) m_vm[k] = 12'h000;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_dout", 32'(io_dout), 32'd0);
    chk("rst_wait", 32'(io_wait), 32'd0);
    chk("rst_stb", 32'({cfg_stb, vmode_stb}), 32'd0);
    check_state("rst");
    reset_n = 1'b1;
    @(posedge clk_sys); #1;

    pw_q = {16'h0068};
    run_frame(16'h0001, 1, 16'h0);
    pw_q = {16'h1234, 16'hFFFF};
    run_frame(16'h0001, 2, 16'h0);
    pw_q = {16'd750, 16'd5, 16'd20, 16'd5, 16'd1650, 16'd110, 16'd220, 16'd40};
    run_frame(16'h0020, 1, 16'h0);
    pw_q = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    run_frame(16'h0020, 1, 16'h0);
    pw_q = {16'h0055};
    run_frame(16'h0001, 1, 16'h0);
    pw_q = {16'h1111, 16'h2222};
    run_frame(16'h0002, 1, 16'h0A5A);
    pw_q = {16'hAAAA, 16'hBBBB};
    run_frame(16'h0002, 10, 16'h3C3C);
    pw_q = {16'h0123, 16'h4567, 16'h89AB};
    run_frame(16'h007F, 10, 16'h0);
    pw_q.delete();
    for (int i = 0; i < 18; i++) pw_q.push_back(16'h0100 + 16'(i));
    run_frame(16'h0001, 1, 16'h0);

    // abort and a word on the same edge: the word must be dropped
    io_uio = 1'b1;
    @(posedge clk_sys); #1;
    send_word(16'h0001, 1, wv, cs, vs, d0, de);
    io_uio = 1'b0; io_strobe = 1'b1; io_din = 16'hBEEF;
    @(posedge clk_sys); #1;
    io_strobe = 1'b0;
    @(posedge clk_sys); #1;
    chk("abort_dout", 32'(io_dout), 32'd0);
    check_state("abort");

    for (int f = 0; f < 24; f++) begin
      case ($urandom_range(0, 3))
        0: cmd = 8'h01;
        1: cmd = 8'h02;
        2: cmd = 8'h20;
        default: begin
          cmd = 8'($urandom_range(3, 255));
          if (cmd == 8'h20) cmd = 8'h7F;
        end
      endcase
      nw = $urandom_range(0, 20);
      pw_q.delete();
      for (int i = 0; i < nw; i++) pw_q.push_back(16'($urandom));
      run_frame({8'($urandom), cmd}, $urandom_range(1, 3), 16'($urandom));
    end

    pw_q = {16'h00C3};
    run_frame(16'h0001, 1, 16'h0);

    // asynchronous reset in the middle of a skipped frame
    io_uio = 1'b1;
    @(posedge clk_sys); #1;
    send_word(16'h007F, 1, wv, cs, vs, d0, de);
    io_strobe = 1'b1; io_din = 16'h5A5A;
    @(posedge clk_sys); #3;
    reset_n = 1'b0;
    #1;
    m_cfg = CFG_INIT; m_ready = 1'b0;
    for (int k = 0; k < VW; k++) m_vm[k] = 12'h000;
    chk("midrst_dout", 32'(io_dout), 32'd0);
    chk("midrst_wait", 32'(io_wait), 32'd0);
    check_state("midrst");
    io_uio = 1'b0; io_strobe = 1'b0;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    pw_q = {16'h0F0F};
    run_frame(16'h0001, 1, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
